microcode_sequencer: RTL and testbench
======================================

Name: microcode_sequencer

Overview:
Parametrised successor to the fixed 6-step SAP-1 controller. Issues one registered 16-bit control word per clock from a microcode table indexed by step, opcode and ALU flags. Supports an extended opcode set with conditional jumps, store and output, optional early end of instruction, a run/stall input and a sticky halt. Sits between the instruction register/flags and every bus-driving datapath block.

Parameters:
NUM_STEPS, 6, ring-counter length in T-states; legal range 6..8; steps >= 6 emit zero words.
EARLY_END, 1, 1 = step returns to 0 after the instruction's last non-empty step; 0 = always run all NUM_STEPS.
STEP_W, 3, width of step counter; must satisfy 2**STEP_W >= NUM_STEPS.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
run  in  1  1 = advance; 0 = stall
opcode  in  4  IR upper nibble
flag_c  in  1  carry flag
flag_z  in  1  zero flag
ctrl  out  16  control word; bits 15..0 = HLT, PC_INC, PC_EN, PC_LOAD, MEM_LOAD, MEM_EN, RAM_WE, IR_LOAD, IR_EN, A_LOAD, A_EN, B_LOAD, ADDER_SUB, ADDER_EN, OUT_LOAD, FLAGS_LOAD
step  out  STEP_W  current T-state
halted  out  1  sticky halt
illegal  out  1  illegal-opcode trap (optional feature)

Behaviour:
- Reset: step=0, ctrl=0, halted=0, illegal=0. Reset overrides run and halt.
- Every edge with run=1 and halted=0: ctrl <= decode(step, opcode, flags), and step <= next. ctrl therefore shows the word for the step held before the edge.
- run=0: step holds and ctrl <= 0, so no side effects during a stall.
- Fetch steps:
  - T0: PC_EN|MEM_LOAD (0x2800)
  - T1: MEM_EN|IR_LOAD (0x0500)
  - T2: PC_INC (0x4000)
  - Opcode and flags are sampled only at the edges decoding T3 and later. IR is stable by then.
- Execute steps (opcode: T3 / T4 / T5):
  - LDA 0x0: IR_EN|MEM_LOAD / MEM_EN|A_LOAD
  - ADD 0x1: IR_EN|MEM_LOAD / MEM_EN|B_LOAD / ADDER_EN|A_LOAD|FLAGS_LOAD
  - SUB 0x2: as ADD, with ADDER_SUB in T5
  - STA 0x3: IR_EN|MEM_LOAD / A_EN|RAM_WE
  - LDI 0x4: IR_EN|A_LOAD
  - JMP 0x5: IR_EN|PC_LOAD
  - JC 0x6: IR_EN|PC_LOAD if flag_c=1, else zero word
  - JZ 0x7: as JC using flag_z
  - OUT 0xE: A_EN|OUT_LOAD
  - HLT 0xF: HLT
  - 0x8–0xD: NOP (zero word)
- Step sequencing:
  - EARLY_END=1: last step is T3 for LDI/JMP/JC/JZ/OUT/NOP, T4 for LDA/STA, T5 for ADD/SUB; next step is 0. A not-taken jump also ends at T3.
  - EARLY_END=0 or otherwise: step wraps NUM_STEPS-1 -> 0.
- Halt: at the edge that issues the HLT word, halted <= 1. Thereafter ctrl holds 0x8000 and step freezes, regardless of run. Only rst clears halt.
- Reset mid-instruction: next cycle shows step=0, ctrl=0. No partial word persists.

Optional Feature:
- Macro SEQ_ILLEGAL_TRAP_EN.
- Defined: opcodes 0x8–0xD at T3 issue the HLT word and set halted=1 and illegal=1, both sticky until rst.
- Undefined: those opcodes are NOPs and illegal is tied to 0.

Decomposition:
- Package sap_ctrl_pkg holds:
  - control-bit index constants and CTRL_W=16
  - opcode localparams (OP_LDA..OP_HLT)
  - fetch word constants
- Sub-module microcode_rom: purely combinational map (step, opcode, flag_c, flag_z) -> {word[15:0], last}. The sequencer holds step, ctrl, halted and illegal registers.

Test Plan:
1. Reset, run=1, opcode=0x0 → ctrl sequence 0x2800, 0x0500, 0x4000, 0x0880, 0x0440, then 0x2800 (EARLY_END=1, 5-cycle instruction).
2. Opcode=0x2 (SUB) → T4 0x0410, T5 0x004D. With EARLY_END=0, NUM_STEPS=8 → two 0x0000 words before the next 0x2800.
3. Opcode=0x6 with flag_c=1 → T3 0x1080, then step 0. With flag_c=0 → T3 0x0000, then step 0.
4. Opcode=0x3 (STA) → T4 0x0220. Opcode=0xE (OUT) → T3 0x0022.
5. Opcode=0xF → ctrl=0x8000 and halted=1, held for 20 cycles with run toggling. rst=1 → step=0, ctrl=0, halted=0.
6. run=0 at step 4 for 3 cycles → step stays 4, ctrl=0x0000; resume → 0x0440. With SEQ_ILLEGAL_TRAP_EN and opcode=0xA → illegal=1, halted=1.

Source files
------------

// File: rtl/sap_ctrl_pkg.sv
// rtl/sap_ctrl_pkg.sv - control-word bit layout, opcodes and fetch words for the SAP microcode sequencer
package sap_ctrl_pkg;

    localparam int CTRL_W = 16;

    localparam int B_HLT        = 15;
    localparam int B_PC_INC     = 14;
    localparam int B_PC_EN      = 13;
    localparam int B_PC_LOAD    = 12;
    localparam int B_MEM_LOAD   = 11;
    localparam int B_MEM_EN     = 10;
    localparam int B_RAM_WE     = 9;
    localparam int B_IR_LOAD    = 8;
    localparam int B_IR_EN      = 7;
    localparam int B_A_LOAD     = 6;
    localparam int B_A_EN       = 5;
    localparam int B_B_LOAD     = 4;
    localparam int B_ADDER_SUB  = 3;
    localparam int B_ADDER_EN   = 2;
    localparam int B_OUT_LOAD   = 1;
    localparam int B_FLAGS_LOAD = 0;

    localparam logic [CTRL_W-1:0] C_HLT        = 16'd1 << B_HLT;
    localparam logic [CTRL_W-1:0] C_PC_INC     = 16'd1 << B_PC_INC;
    localparam logic [CTRL_W-1:0] C_PC_EN      = 16'd1 << B_PC_EN;
    localparam logic [CTRL_W-1:0] C_PC_LOAD    = 16'd1 << B_PC_LOAD;
    localparam logic [CTRL_W-1:0] C_MEM_LOAD   = 16'd1 << B_MEM_LOAD;
    localparam logic [CTRL_W-1:0] C_MEM_EN     = 16'd1 << B_MEM_EN;
    localparam logic [CTRL_W-1:0] C_RAM_WE     = 16'd1 << B_RAM_WE;
    localparam logic [CTRL_W-1:0] C_IR_LOAD    = 16'd1 << B_IR_LOAD;
    localparam logic [CTRL_W-1:0] C_IR_EN      = 16'd1 << B_IR_EN;
    localparam logic [CTRL_W-1:0] C_A_LOAD     = 16'd1 << B_A_LOAD;
    localparam logic [CTRL_W-1:0] C_A_EN       = 16'd1 << B_A_EN;
    localparam logic [CTRL_W-1:0] C_B_LOAD     = 16'd1 << B_B_LOAD;
    localparam logic [CTRL_W-1:0] C_ADDER_SUB  = 16'd1 << B_ADDER_SUB;
    localparam logic [CTRL_W-1:0] C_ADDER_EN   = 16'd1 << B_ADDER_EN;
    localparam logic [CTRL_W-1:0] C_OUT_LOAD   = 16'd1 << B_OUT_LOAD;
    localparam logic [CTRL_W-1:0] C_FLAGS_LOAD = 16'd1 << B_FLAGS_LOAD;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_LDI = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_JC  = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [CTRL_W-1:0] W_T0 = C_PC_EN | C_MEM_LOAD;
    localparam logic [CTRL_W-1:0] W_T1 = C_MEM_EN | C_IR_LOAD;
    localparam logic [CTRL_W-1:0] W_T2 = C_PC_INC;

    // Opcodes 0x8..0xD have no defined execute behaviour.
    function automatic logic is_unassigned_op(input logic [3:0] op);
        return (op >= 4'h8) && (op <= 4'hD);
    endfunction

endpackage

// File: rtl/microcode_rom.sv
// rtl/microcode_rom.sv - combinational (step, opcode, flags) -> control word and last-step map
module microcode_rom
    import sap_ctrl_pkg::*;
#(
    parameter int STEP_W = 3
) (
    input  logic [STEP_W-1:0] step,
    input  logic [3:0]        opcode,
    input  logic              flag_c,
    input  logic              flag_z,
    output logic [CTRL_W-1:0] word,
    output logic              last
);

    // Fetch words ignore opcode/flags; execute words decode from T3 on; T6+ are empty.
    always_comb begin
        word = '0;
        last = 1'b0;
        case (int'(step))
            0: word = W_T0;
            1: word = W_T1;
            2: word = W_T2;
            3: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: word = C_IR_EN | C_MEM_LOAD;
                    OP_LDI: begin
                        word = C_IR_EN | C_A_LOAD;
                        last = 1'b1;
                    end
                    OP_JMP: begin
                        word = C_IR_EN | C_PC_LOAD;
                        last = 1'b1;
                    end
                    OP_JC: begin
                        word = flag_c ? (C_IR_EN | C_PC_LOAD) : '0;
                        last = 1'b1;
                    end
                    OP_JZ: begin
                        word = flag_z ? (C_IR_EN | C_PC_LOAD) : '0;
                        last = 1'b1;
                    end
                    OP_OUT: begin
                        word = C_A_EN | C_OUT_LOAD;
                        last = 1'b1;
                    end
                    OP_HLT: word = C_HLT;
                    default: begin
`ifdef SEQ_ILLEGAL_TRAP_EN
                        word = C_HLT;
`else
                        word = '0;
`endif
                        last = 1'b1;
                    end
                endcase
            end
            4: begin
                case (opcode)
                    OP_LDA: begin
                        word = C_MEM_EN | C_A_LOAD;
                        last = 1'b1;
                    end
                    OP_ADD, OP_SUB: word = C_MEM_EN | C_B_LOAD;
                    OP_STA: begin
                        word = C_A_EN | C_RAM_WE;
                        last = 1'b1;
                    end
                    default: word = '0;
                endcase
            end
            5: begin
                case (opcode)
                    OP_ADD: begin
                        word = C_ADDER_EN | C_A_LOAD | C_FLAGS_LOAD;
                        last = 1'b1;
                    end
                    OP_SUB: begin
                        word = C_ADDER_EN | C_ADDER_SUB | C_A_LOAD | C_FLAGS_LOAD;
                        last = 1'b1;
                    end
                    default: word = '0;
                endcase
            end
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/microcode_sequencer.sv
// rtl/microcode_sequencer.sv - registered SAP control-word sequencer; SEQ_ILLEGAL_TRAP_EN enables the illegal-opcode trap
module microcode_sequencer
    import sap_ctrl_pkg::*;
#(
    parameter int NUM_STEPS = 6,
    parameter int EARLY_END = 1,
    parameter int STEP_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [3:0]        opcode,
    input  logic              flag_c,
    input  logic              flag_z,
    output logic [CTRL_W-1:0] ctrl,
    output logic [STEP_W-1:0] step,
    output logic              halted,
    output logic              illegal
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    logic [STEP_W-1:0] step_q, step_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              halted_q, halted_d;
    logic [CTRL_W-1:0] rom_word;
    logic              rom_last;
    logic              end_of_instr;

    microcode_rom #(.STEP_W(STEP_W)) u_rom (
        .step   (step_q),
        .opcode (opcode),
        .flag_c (flag_c),
        .flag_z (flag_z),
        .word   (rom_word),
        .last   (rom_last)
    );

`ifdef SEQ_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
`endif

    // Next step/word: halt dominates stall, stall blanks the word, otherwise issue and advance.
    always_comb begin
        step_d       = step_q;
        ctrl_d       = ctrl_q;
        halted_d     = halted_q;
        end_of_instr = ((EARLY_END != 0) && rom_last) || (step_q == LAST_STEP);
`ifdef SEQ_ILLEGAL_TRAP_EN
        illegal_d    = illegal_q;
`endif
        if (halted_q) begin
            ctrl_d = C_HLT;
        end else if (!run) begin
            ctrl_d = '0;
        end else begin
            ctrl_d = rom_word;
            step_d = end_of_instr ? '0 : step_q + STEP_W'(1);
            if (rom_word[B_HLT]) begin
                halted_d = 1'b1;
            end
`ifdef SEQ_ILLEGAL_TRAP_EN
            if ((int'(step_q) == 3) && is_unassigned_op(opcode)) begin
                illegal_d = 1'b1;
            end
`endif
        end
    end

    // State registers with synchronous reset overriding run and halt.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_q   <= '0;
            ctrl_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            ctrl_q   <= ctrl_d;
            halted_q <= halted_d;
        end
    end

`ifdef SEQ_ILLEGAL_TRAP_EN
    // Sticky illegal-opcode flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    assign ctrl   = ctrl_q;
    assign step   = step_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// tb/tb_microcode_sequencer.sv - directed vector bench for microcode_sequencer
module tb_microcode_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [3:0]  opcode = 4'h0;
    logic        flag_c = 1'b0;
    logic        flag_z = 1'b0;

    logic [15:0] ctrl;
    logic [2:0]  step;
    logic        halted;
    logic        illegal;

    logic [15:0] ctrl8;
    logic [2:0]  step8;
    logic        halted8;
    logic        illegal8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    microcode_sequencer #(.NUM_STEPS(6), .EARLY_END(1), .STEP_W(3)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .opcode  (opcode),
        .flag_c  (flag_c),
        .flag_z  (flag_z),
        .ctrl    (ctrl),
        .step    (step),
        .halted  (halted),
        .illegal (illegal)
    );

    microcode_sequencer #(.NUM_STEPS(8), .EARLY_END(0), .STEP_W(3)) u_dut8 (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .opcode  (opcode),
        .flag_c  (flag_c),
        .flag_z  (flag_z),
        .ctrl    (ctrl8),
        .step    (step8),
        .halted  (halted8),
        .illegal (illegal8)
    );

    typedef struct {
        logic        rst;
        logic        run;
        logic [3:0]  op;
        logic        fc;
        logic        fz;
        logic [15:0] ctrl;
        logic [2:0]  step;
        logic        halted;
        logic        illegal;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic rn, input logic [3:0] op, input logic fc,
                       input logic fz, input logic [15:0] c, input logic [2:0] s,
                       input logic h, input logic il);
        vec_t v;
        v.rst = r; v.run = rn; v.op = op; v.fc = fc; v.fz = fz;
        v.ctrl = c; v.step = s; v.halted = h; v.illegal = il;
        vq.push_back(v);
    endtask

    task automatic fetch(input logic [3:0] op, input logic fc, input logic fz);
        add(0, 1, op, fc, fz, 16'h2800, 3'd1, 0, 0);
        add(0, 1, op, fc, fz, 16'h0500, 3'd2, 0, 0);
        add(0, 1, op, fc, fz, 16'h4000, 3'd3, 0, 0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        logic [15:0] sub8_ctrl [9];
        logic [2:0]  sub8_step [9];

        // reset state
        add(1, 0, 4'h0, 0, 0, 16'h0000, 3'd0, 0, 0);
        // LDA, 5-cycle instruction, then next fetch
        fetch(4'h0, 0, 0);
        add(0, 1, 4'h0, 0, 0, 16'h0880, 3'd4, 0, 0);
        add(0, 1, 4'h0, 0, 0, 16'h0440, 3'd0, 0, 0);
        // SUB
        fetch(4'h2, 0, 0);
        add(0, 1, 4'h2, 0, 0, 16'h0880, 3'd4, 0, 0);
        add(0, 1, 4'h2, 0, 0, 16'h0410, 3'd5, 0, 0);
        add(0, 1, 4'h2, 0, 0, 16'h004D, 3'd0, 0, 0);
        // ADD
        fetch(4'h1, 0, 0);
        add(0, 1, 4'h1, 0, 0, 16'h0880, 3'd4, 0, 0);
        add(0, 1, 4'h1, 0, 0, 16'h0410, 3'd5, 0, 0);
        add(0, 1, 4'h1, 0, 0, 16'h0045, 3'd0, 0, 0);
        // JC taken / not taken, JZ taken / not taken (wrong flag set)
        fetch(4'h6, 1, 0);
        add(0, 1, 4'h6, 1, 0, 16'h1080, 3'd0, 0, 0);
        fetch(4'h6, 0, 1);
        add(0, 1, 4'h6, 0, 1, 16'h0000, 3'd0, 0, 0);
        fetch(4'h7, 0, 1);
        add(0, 1, 4'h7, 0, 1, 16'h1080, 3'd0, 0, 0);
        fetch(4'h7, 1, 0);
        add(0, 1, 4'h7, 1, 0, 16'h0000, 3'd0, 0, 0);
        // STA, OUT, LDI, JMP
        fetch(4'h3, 0, 0);
        add(0, 1, 4'h3, 0, 0, 16'h0880, 3'd4, 0, 0);
        add(0, 1, 4'h3, 0, 0, 16'h0220, 3'd0, 0, 0);
        fetch(4'hE, 0, 0);
        add(0, 1, 4'hE, 0, 0, 16'h0022, 3'd0, 0, 0);
        fetch(4'h4, 0, 0);
        add(0, 1, 4'h4, 0, 0, 16'h00C0, 3'd0, 0, 0);
        fetch(4'h5, 0, 0);
        add(0, 1, 4'h5, 0, 0, 16'h1080, 3'd0, 0, 0);
        // stall at step 4 for 3 cycles, then resume
        fetch(4'h0, 0, 0);
        add(0, 1, 4'h0, 0, 0, 16'h0880, 3'd4, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 4'h0, 0, 0, 16'h0000, 3'd4, 0, 0);
        add(0, 1, 4'h0, 0, 0, 16'h0440, 3'd0, 0, 0);
`ifdef SEQ_ILLEGAL_TRAP_EN
        // unassigned opcode traps: halt word, sticky halted and illegal
        fetch(4'hA, 0, 0);
        add(0, 1, 4'hA, 0, 0, 16'h8000, 3'd0, 1, 1);
        for (int i = 0; i < 4; i++) add(0, i[0], 4'h0, 0, 0, 16'h8000, 3'd0, 1, 1);
        add(1, 1, 4'h0, 0, 0, 16'h0000, 3'd0, 0, 0);
`else
        // unassigned opcode is a one-step NOP
        fetch(4'hA, 0, 0);
        add(0, 1, 4'hA, 0, 0, 16'h0000, 3'd0, 0, 0);
`endif
        // reset mid-instruction, then a clean fetch
        add(0, 1, 4'h0, 0, 0, 16'h2800, 3'd1, 0, 0);
        add(0, 1, 4'h0, 0, 0, 16'h0500, 3'd2, 0, 0);
        add(1, 1, 4'h0, 0, 0, 16'h0000, 3'd0, 0, 0);
        add(0, 1, 4'h0, 0, 0, 16'h2800, 3'd1, 0, 0);
        add(1, 0, 4'h0, 0, 0, 16'h0000, 3'd0, 0, 0);
        // HLT: sticky, holds for 20 cycles with run toggling, cleared by reset
        fetch(4'hF, 0, 0);
        add(0, 1, 4'hF, 0, 0, 16'h8000, 3'd4, 1, 0);
        for (int i = 0; i < 20; i++) add(0, i[0], 4'h0, 0, 0, 16'h8000, 3'd4, 1, 0);
        add(1, 1, 4'h0, 0, 0, 16'h0000, 3'd0, 0, 0);

        foreach (vq[i]) begin
            rst = vq[i].rst; run = vq[i].run; opcode = vq[i].op;
            flag_c = vq[i].fc; flag_z = vq[i].fz;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d{ctrl,step,halted,illegal}", i),
                {11'd0, ctrl, step, halted, illegal},
                {11'd0, vq[i].ctrl, vq[i].step, vq[i].halted, vq[i].illegal});
        end

        // NUM_STEPS=8, EARLY_END=0: SUB runs all eight steps, two empty words before next fetch
        sub8_ctrl = '{16'h2800, 16'h0500, 16'h4000, 16'h0880, 16'h0410, 16'h004D,
                      16'h0000, 16'h0000, 16'h2800};
        sub8_step = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
        rst = 1'b1; run = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0; run = 1'b1; opcode = 4'h2; flag_c = 1'b0; flag_z = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("sub8_cyc%0d{ctrl,step}", i), {13'd0, ctrl8, step8},
                {13'd0, sub8_ctrl[i], sub8_step[i]});
        end
        // LDI without early end still walks to step 7 then wraps
        opcode = 4'h4;
        for (int i = 0; i < 7; i++) @(posedge clk);
        #1;
        chk("ldi8_wrap_step", {29'd0, step8}, {29'd0, 3'd0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
